// File: rtl/axis_pkt_arb_pkg.sv
// ============================================================================
// Module      : axis_pkt_arb_pkg
// Description : Shared constants for the AXI-Stream packet arbiter: register
//               map, version fields, CONTROL/STATUS bit positions, FIFO word
//               layout and arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_pkt_arb_pkg;

    localparam logic [31:0] c_REG_CONTROL       = 32'h0000_0000;
    localparam logic [31:0] c_REG_VERSION       = 32'h0000_0004;
    localparam logic [31:0] c_REG_STATUS        = 32'h0000_0008;
    localparam logic [31:0] c_REG_PKTCNT_BASE   = 32'h0000_000C;
    localparam logic [31:0] c_REG_PKTCNT_STRIDE = 32'h0000_0004;

    localparam logic [3:0]  c_VER_MAJOR = 4'd2;
    localparam logic [11:0] c_VER_MINOR = 12'd0;
    localparam logic [15:0] c_VER_REV   = 16'd0;
    localparam logic [31:0] c_VERSION   = {c_VER_MAJOR, c_VER_MINOR, c_VER_REV};

    localparam int c_CTRL_ENABLE_LSB  = 0;
    localparam int c_CTRL_FLUSH_BIT   = 31;
    localparam int c_STATUS_FULL_LSB  = 16;

    // FIFO word is {tuser, tlast, tdata}; sideband offsets sit above tdata
    localparam int c_FW_LAST_OFS = 0;
    localparam int c_FW_USER_OFS = 1;
    localparam int c_FW_SIDEBAND = 2;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } arb_state_t;

    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_pkt_arb_fifo.sv
// ============================================================================
// Module      : axis_pkt_arb_fifo
// Description : Synchronous first-word-fall-through FIFO with flush; one per
//               arbiter input channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_pkt_arb_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    // Flush wins over a same-cycle write so the dropped word never lands
    assign w_wr = i_wr_en && !o_full && !i_flush;
    assign w_rd = i_rd_en && !o_empty && !i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/axis_pkt_arbiter.sv
// ============================================================================
// Module      : axis_pkt_arbiter
// Description : Round-robin packet arbiter merging NUM_CHANNELS AXI-Stream
//               inputs into one output, with a small register interface.
//               Optional per-channel packet counters: AXIS_PKT_ARB_COUNTERS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_pkt_arbiter
    import axis_pkt_arb_pkg::*;
#(
    parameter int NUM_CHANNELS    = 2,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH      = 8,
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                                  i_axi_clk,
    input  logic                                  i_axi_rst,
    input  logic [ADDR_WIDTH-1:0]                 i_reg_address,
    input  logic                                  i_reg_in_rdy,
    input  logic [DATA_WIDTH-1:0]                 i_reg_in_data,
    output logic                                  o_reg_in_ack_stb,
    input  logic                                  i_reg_out_req,
    output logic                                  o_reg_out_rdy_stb,
    output logic [DATA_WIDTH-1:0]                 o_reg_out_data,
    output logic                                  o_reg_invalid_addr,
    input  logic [NUM_CHANNELS-1:0]               i_axis_in_tuser,
    input  logic [NUM_CHANNELS-1:0]               i_axis_in_tvalid,
    input  logic [NUM_CHANNELS-1:0]               i_axis_in_tlast,
    input  logic [NUM_CHANNELS*AXIS_DATA_WIDTH-1:0] i_axis_in_tdata,
    output logic [NUM_CHANNELS-1:0]               o_axis_in_tready,
    output logic                                  o_axis_out_tuser,
    output logic                                  o_axis_out_tvalid,
    output logic                                  o_axis_out_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]            o_axis_out_tdata,
    output logic [chan_width(NUM_CHANNELS)-1:0]   o_axis_out_tdest,
    input  logic                                  i_axis_out_tready
);

    localparam int c_CW = chan_width(NUM_CHANNELS);
    localparam int c_FW = AXIS_DATA_WIDTH + c_FW_SIDEBAND;

    // ------------------------------------------------------------------
    // Register decode strobes
    // ------------------------------------------------------------------
    logic                    w_wr_stb;
    logic                    w_rd_stb;
    logic                    w_ctrl_wr;
    logic                    w_flush;
    logic                    w_addr_ok;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic                    w_unused;

    logic [NUM_CHANNELS-1:0] r_enable;
    logic                    r_ack;
    logic                    r_rdy;
    logic                    r_invalid;
    logic [DATA_WIDTH-1:0]   r_rd_data;

    assign w_wr_stb  = i_reg_in_rdy;
    assign w_rd_stb  = i_reg_out_req && !i_reg_in_rdy;
    assign w_ctrl_wr = w_wr_stb && (i_reg_address == ADDR_WIDTH'(c_REG_CONTROL));
    assign w_flush   = w_ctrl_wr && i_reg_in_data[c_CTRL_FLUSH_BIT];
    assign w_unused  = ^i_reg_in_data;

    // ------------------------------------------------------------------
    // Per-channel FIFOs
    // ------------------------------------------------------------------
    logic [NUM_CHANNELS-1:0] w_fifo_wr;
    logic [NUM_CHANNELS-1:0] w_fifo_rd;
    logic [NUM_CHANNELS-1:0] w_empty;
    logic [NUM_CHANNELS-1:0] w_full;
    logic [NUM_CHANNELS-1:0] w_not_empty;
    logic [c_FW-1:0]         w_fifo_dout [NUM_CHANNELS];

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [c_CW-1:0]         r_grant;
    logic [c_CW-1:0]         w_grant_nxt;
    logic [c_CW-1:0]         r_last_grant;
    logic [c_CW-1:0]         w_last_grant_nxt;
    logic                    w_xfer;

    assign o_axis_in_tready = r_enable & ~w_full;
    assign w_fifo_wr        = i_axis_in_tvalid & o_axis_in_tready;
    assign w_not_empty      = ~w_empty;

    genvar g;
    generate
        for (g = 0; g < NUM_CHANNELS; g++) begin : g_chan
            assign w_fifo_rd[g] = w_xfer && (r_grant == c_CW'(g));

            axis_pkt_arb_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (c_FW)
            ) u_fifo (
                .clk       (i_axi_clk),
                .rst       (i_axi_rst),
                .i_flush   (w_flush),
                .i_wr_en   (w_fifo_wr[g]),
                .i_wr_data ({i_axis_in_tuser[g], i_axis_in_tlast[g],
                             i_axis_in_tdata[g*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH]}),
                .i_rd_en   (w_fifo_rd[g]),
                .o_rd_data (w_fifo_dout[g]),
                .o_empty   (w_empty[g]),
                .o_full    (w_full[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output path: head of the granted FIFO, zeroed when not valid
    // ------------------------------------------------------------------
    logic [c_FW-1:0] w_head;
    logic            w_out_valid;
    logic            w_head_last;

    assign w_head      = w_fifo_dout[r_grant];
    assign w_head_last = w_head[AXIS_DATA_WIDTH + c_FW_LAST_OFS];
    assign w_out_valid = (r_state == S_GRANT) && w_not_empty[r_grant];
    assign w_xfer      = w_out_valid && i_axis_out_tready;

    assign o_axis_out_tvalid = w_out_valid;
    assign o_axis_out_tdata  = w_out_valid ? w_head[AXIS_DATA_WIDTH-1:0] : '0;
    assign o_axis_out_tlast  = w_out_valid && w_head_last;
    assign o_axis_out_tuser  = w_out_valid && w_head[AXIS_DATA_WIDTH + c_FW_USER_OFS];
    assign o_axis_out_tdest  = (r_state == S_GRANT) ? r_grant : '0;

    // ------------------------------------------------------------------
    // Round-robin pick: first non-empty channel after the last grant
    // ------------------------------------------------------------------
    logic            w_pick_valid;
    logic [c_CW-1:0] w_pick;
    int              w_pick_idx;

    always_comb begin
        w_pick_valid = 1'b0;
        w_pick       = '0;
        w_pick_idx   = 0;
        // Scan farthest first so the nearest candidate is assigned last
        for (int k = NUM_CHANNELS; k >= 1; k--) begin
            w_pick_idx = (int'(r_last_grant) + k) % NUM_CHANNELS;
            if (w_not_empty[c_CW'(w_pick_idx)]) begin
                w_pick_valid = 1'b1;
                w_pick       = c_CW'(w_pick_idx);
            end
        end
    end

    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_CW'(NUM_CHANNELS - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        if (w_flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        w_state_nxt      = S_GRANT;
                        w_grant_nxt      = w_pick;
                        w_last_grant_nxt = w_pick;
                    end
                end
                S_GRANT: begin
                    if (w_xfer && w_head_last) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional per-channel packet counters
    // ------------------------------------------------------------------
`ifdef AXIS_PKT_ARB_COUNTERS_EN
    logic [31:0]             r_pkt_cnt [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] w_cnt_sel;

    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) r_pkt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (w_wr_stb && w_cnt_sel[i])
                    r_pkt_cnt[i] <= '0;
                else if (w_xfer && w_head_last && (r_grant == c_CW'(i)))
                    r_pkt_cnt[i] <= r_pkt_cnt[i] + 32'd1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Register read/decode
    // ------------------------------------------------------------------
    always_comb begin
        w_addr_ok = 1'b0;
        w_rd_data = '0;
`ifdef AXIS_PKT_ARB_COUNTERS_EN
        w_cnt_sel = '0;
`endif
        if (i_reg_address == ADDR_WIDTH'(c_REG_CONTROL)) begin
            w_addr_ok                        = 1'b1;
            w_rd_data[NUM_CHANNELS-1:0]      = r_enable;
        end else if (i_reg_address == ADDR_WIDTH'(c_REG_VERSION)) begin
            w_addr_ok                        = 1'b1;
            w_rd_data                        = DATA_WIDTH'(c_VERSION);
        end else if (i_reg_address == ADDR_WIDTH'(c_REG_STATUS)) begin
            w_addr_ok                        = 1'b1;
            w_rd_data[NUM_CHANNELS-1:0]      = w_not_empty;
            w_rd_data[c_STATUS_FULL_LSB +: NUM_CHANNELS] = w_full;
        end
`ifdef AXIS_PKT_ARB_COUNTERS_EN
        for (int n = 0; n < NUM_CHANNELS; n++) begin
            if (i_reg_address ==
                ADDR_WIDTH'(c_REG_PKTCNT_BASE + c_REG_PKTCNT_STRIDE * 32'(n))) begin
                w_addr_ok    = 1'b1;
                w_cnt_sel[n] = 1'b1;
                w_rd_data    = DATA_WIDTH'(r_pkt_cnt[n]);
            end
        end
`endif
    end

    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            r_enable  <= '0;
            r_ack     <= 1'b0;
            r_rdy     <= 1'b0;
            r_invalid <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_ack     <= w_wr_stb;
            r_rdy     <= w_rd_stb;
            r_invalid <= (w_wr_stb || w_rd_stb) && !w_addr_ok;
            r_rd_data <= (w_rd_stb && w_addr_ok) ? w_rd_data : '0;
            if (w_ctrl_wr)
                r_enable <= i_reg_in_data[c_CTRL_ENABLE_LSB +: NUM_CHANNELS];
        end
    end

    assign o_reg_in_ack_stb   = r_ack;
    assign o_reg_out_rdy_stb  = r_rdy;
    assign o_reg_out_data     = r_rd_data;
    assign o_reg_invalid_addr = r_invalid;

endmodule

`default_nettype wire

// File: tb/tb_axis_pkt_arbiter.sv
// ============================================================================
// Module      : tb_axis_pkt_arbiter
// Description : Self-checking bench for axis_pkt_arbiter (register table plus
//               scoreboarded stream scenarios).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axis_pkt_arbiter;

    localparam int NC = 2;
    localparam int W  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       reg_addr = '0;
    logic              reg_in_rdy = 1'b0;
    logic [31:0]       reg_in_data = '0;
    logic              reg_ack;
    logic              reg_out_req = 1'b0;
    logic              reg_rdy;
    logic [31:0]       reg_out_data;
    logic              reg_inv;
    logic [NC-1:0]     in_tuser = '0;
    logic [NC-1:0]     in_tvalid = '0;
    logic [NC-1:0]     in_tlast = '0;
    logic [NC*W-1:0]   in_tdata = '0;
    logic [NC-1:0]     in_tready;
    logic              out_tuser;
    logic              out_tvalid;
    logic              out_tlast;
    logic [W-1:0]      out_tdata;
    logic [0:0]        out_tdest;
    logic              out_tready = 1'b0;

    axis_pkt_arbiter #(
        .NUM_CHANNELS (NC), .AXIS_DATA_WIDTH (W), .FIFO_DEPTH (8),
        .ADDR_WIDTH (16), .DATA_WIDTH (32)
    ) dut (
        .i_axi_clk (clk), .i_axi_rst (rst),
        .i_reg_address (reg_addr), .i_reg_in_rdy (reg_in_rdy),
        .i_reg_in_data (reg_in_data), .o_reg_in_ack_stb (reg_ack),
        .i_reg_out_req (reg_out_req), .o_reg_out_rdy_stb (reg_rdy),
        .o_reg_out_data (reg_out_data), .o_reg_invalid_addr (reg_inv),
        .i_axis_in_tuser (in_tuser), .i_axis_in_tvalid (in_tvalid),
        .i_axis_in_tlast (in_tlast), .i_axis_in_tdata (in_tdata),
        .o_axis_in_tready (in_tready),
        .o_axis_out_tuser (out_tuser), .o_axis_out_tvalid (out_tvalid),
        .o_axis_out_tlast (out_tlast), .o_axis_out_tdata (out_tdata),
        .o_axis_out_tdest (out_tdest), .i_axis_out_tready (out_tready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        user;
        logic [0:0]  dest;
    } beat_t;

    beat_t sbq[$];
    beat_t mon_got;
    beat_t mon_exp;
    bit    mon_arm       = 1'b0;
    int    mon_first_cyc = -1;
    bit    gap_chk       = 1'b0;
    bit    mon_in_pkt    = 1'b0;
    int    last_tlast_cyc = -1;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Output monitor / scoreboard consumer
    always @(negedge clk) begin
        if (!rst && out_tvalid) begin
            if (mon_arm && mon_first_cyc < 0) mon_first_cyc = cyc;
            if (out_tready) begin
                mon_got = {out_tdata, out_tlast, out_tuser, out_tdest};
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_beat: unexpected beat got=0x%0h expected none", mon_got);
                end else begin
                    mon_exp = sbq.pop_front();
                    check("out_beat", 64'(mon_got), 64'(mon_exp));
                end
                if (gap_chk && !mon_in_pkt && last_tlast_cyc >= 0)
                    check("pkt_gap", 64'(cyc - last_tlast_cyc), 64'd2);
                mon_in_pkt = !out_tlast;
                if (out_tlast) last_tlast_cyc = cyc;
            end
        end
    end

    // All tasks start and end 1 ns after a rising edge
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reg_op(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp, input logic inv, input string name);
        reg_addr = addr;
        if (wr) begin reg_in_rdy = 1'b1; reg_in_data = wdata; end
        else    reg_out_req = 1'b1;
        tick(1);
        reg_in_rdy  = 1'b0;
        reg_out_req = 1'b0;
        if (wr) check({name, "_ack"}, 64'(reg_ack), 64'd1);
        else begin
            check({name, "_rdy"}, 64'(reg_rdy), 64'd1);
            check({name, "_data"}, 64'(reg_out_data), 64'(exp));
        end
        check({name, "_inv"}, 64'(reg_inv), 64'(inv));
    endtask

    task automatic push(input int ch, input logic [31:0] d, input logic last,
                        input logic user, input logic expect_out, output int t_in);
        int n;
        n = 0;
        in_tvalid[ch]         = 1'b1;
        in_tlast[ch]          = last;
        in_tuser[ch]          = user;
        in_tdata[ch*W +: W]   = d;
        while (!in_tready[ch] && n < 100) begin tick(1); n++; end
        if (n >= 100) check("push_timeout", 64'd1, 64'd0);
        t_in = cyc;
        if (expect_out) sbq.push_back({d, last, user, 1'(ch)});
        tick(1);
        in_tvalid[ch] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin tick(1); n++; end
        check({name, "_drained"}, 64'(sbq.size()), 64'd0);
        sbq.delete();
    endtask

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        inv;
    } regvec_t;

    regvec_t tbl [16];
    int      t0;
    int      tdummy;

    initial begin
        // Register-map vectors
        tbl[0]  = '{1'b0, 16'h0000, 32'h0,         32'h0,         1'b0};
        tbl[1]  = '{1'b0, 16'h0004, 32'h0,         32'h2000_0000, 1'b0};
        tbl[2]  = '{1'b0, 16'h0008, 32'h0,         32'h0,         1'b0};
        tbl[3]  = '{1'b1, 16'h0004, 32'hDEAD_BEEF, 32'h0,         1'b0};
        tbl[4]  = '{1'b0, 16'h0004, 32'h0,         32'h2000_0000, 1'b0};
        tbl[5]  = '{1'b1, 16'h0008, 32'hFFFF_FFFF, 32'h0,         1'b0};
        tbl[6]  = '{1'b0, 16'h0008, 32'h0,         32'h0,         1'b0};
        tbl[7]  = '{1'b1, 16'h0000, 32'h7FFF_FFFE, 32'h0,         1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 32'h0,         32'h2,         1'b0};
        tbl[9]  = '{1'b1, 16'h0000, 32'h0000_0003, 32'h0,         1'b0};
        tbl[10] = '{1'b0, 16'h0000, 32'h0,         32'h3,         1'b0};
        tbl[11] = '{1'b0, 16'h0040, 32'h0,         32'h0,         1'b1};
        tbl[12] = '{1'b1, 16'h0040, 32'h1,         32'h0,         1'b1};
        tbl[13] = '{1'b0, 16'h0002, 32'h0,         32'h0,         1'b1};
        tbl[14] = '{1'b0, 16'h0014, 32'h0,         32'h0,         1'b1};
`ifdef AXIS_PKT_ARB_COUNTERS_EN
        tbl[15] = '{1'b0, 16'h000C, 32'h0,         32'h0,         1'b0};
`else
        tbl[15] = '{1'b0, 16'h000C, 32'h0,         32'h0,         1'b1};
`endif

        // Reset state
        tick(3);
        @(negedge clk);
        check("rst_tready",  64'(in_tready),   64'd0);
        check("rst_tvalid",  64'(out_tvalid),  64'd0);
        check("rst_tdata",   64'(out_tdata),   64'd0);
        check("rst_side",    64'({out_tlast, out_tuser, out_tdest}), 64'd0);
        check("rst_strobes", 64'({reg_ack, reg_rdy, reg_inv}), 64'd0);
        check("rst_rdata",   64'(reg_out_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(1);

        for (int i = 0; i < 16; i++)
            reg_op(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp, tbl[i].inv,
                   $sformatf("reg%0d", i));

        // Write has priority over a simultaneous read
        reg_addr = 16'h0000; reg_in_data = 32'h3; reg_in_rdy = 1'b1; reg_out_req = 1'b1;
        tick(1);
        reg_in_rdy = 1'b0; reg_out_req = 1'b0;
        check("prio_ack", 64'(reg_ack), 64'd1);
        check("prio_rdy", 64'(reg_rdy), 64'd0);

        // Single 3-word packet on ch0, latency 2
        out_tready = 1'b1;
        mon_arm = 1'b1; mon_first_cyc = -1;
        push(0, 32'hA0, 1'b0, 1'b1, 1'b1, t0);
        push(0, 32'hA1, 1'b0, 1'b0, 1'b1, tdummy);
        push(0, 32'hA2, 1'b1, 1'b0, 1'b1, tdummy);
        wait_drain("s1");
        mon_arm = 1'b0;
        check("s1_latency", 64'(mon_first_cyc - t0), 64'd2);

        // Round robin between two loaded channels with one bubble between packets
        out_tready = 1'b0;
        push(0, 32'hB0, 1'b0, 1'b0, 1'b1, tdummy);
        push(0, 32'hB1, 1'b1, 1'b0, 1'b1, tdummy);
        push(1, 32'hC0, 1'b0, 1'b1, 1'b1, tdummy);
        push(1, 32'hC1, 1'b1, 1'b0, 1'b1, tdummy);
        push(0, 32'hB2, 1'b0, 1'b0, 1'b1, tdummy);
        push(0, 32'hB3, 1'b1, 1'b0, 1'b1, tdummy);
        push(1, 32'hC2, 1'b0, 1'b0, 1'b1, tdummy);
        push(1, 32'hC3, 1'b1, 1'b0, 1'b1, tdummy);
        gap_chk = 1'b1; last_tlast_cyc = -1;
        out_tready = 1'b1;
        wait_drain("s2");
        gap_chk = 1'b0;

        // Fill ch1 to full with output stalled
        out_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("s3_tready_before_full", 64'(in_tready[1]), 64'd1);
            push(1, 32'hD0 + 32'(i), (i == 7), 1'b0, 1'b1, tdummy);
        end
        check("s3_tready_full", 64'(in_tready), 64'b01);
        reg_op(1'b0, 16'h0008, 32'h0, 32'h0002_0002, 1'b0, "s3_status");
        out_tready = 1'b1;
        push(1, 32'hE0, 1'b1, 1'b1, 1'b1, tdummy);
        wait_drain("s3");

        // Flush mid-packet: first word out, remainder discarded
        out_tready = 1'b0;
        push(0, 32'hF0, 1'b0, 1'b0, 1'b1, tdummy);
        push(0, 32'hF1, 1'b0, 1'b0, 1'b0, tdummy);
        push(0, 32'hF2, 1'b1, 1'b0, 1'b0, tdummy);
        begin
            int n;
            n = 0;
            while (!out_tvalid && n < 20) begin tick(1); n++; end
            check("s4_granted", 64'(out_tvalid), 64'd1);
        end
        out_tready = 1'b1;
        tick(1);
        out_tready = 1'b0;
        reg_op(1'b1, 16'h0000, 32'h8000_0003, 32'h0, 1'b0, "s4_flush");
        check("s4_tvalid_after_flush", 64'(out_tvalid), 64'd0);
        reg_op(1'b0, 16'h0008, 32'h0, 32'h0, 1'b0, "s4_status");
        reg_op(1'b0, 16'h0000, 32'h0, 32'h3, 1'b0, "s4_ctrl");
        out_tready = 1'b1;
        tick(6);
        check("s4_no_residue", 64'(sbq.size()), 64'd0);
        sbq.delete();

`ifdef AXIS_PKT_ARB_COUNTERS_EN
        // Packet counters: totals, wrap, clear-on-write
        reg_op(1'b0, 16'h000C, 32'h0, 32'd3, 1'b0, "cnt0_total");
        reg_op(1'b0, 16'h0010, 32'h0, 32'd4, 1'b0, "cnt1_total");
        @(negedge clk);
        dut.r_pkt_cnt[0] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        push(0, 32'h60, 1'b1, 1'b0, 1'b1, tdummy);
        wait_drain("cnt_wrap");
        reg_op(1'b0, 16'h000C, 32'h0, 32'd0, 1'b0, "cnt0_wrap");
        push(0, 32'h61, 1'b1, 1'b0, 1'b1, tdummy);
        wait_drain("cnt_inc");
        reg_op(1'b0, 16'h000C, 32'h0, 32'd1, 1'b0, "cnt0_inc");
        reg_op(1'b1, 16'h000C, 32'hABCD, 32'h0, 1'b0, "cnt0_clr");
        reg_op(1'b0, 16'h000C, 32'h0, 32'd0, 1'b0, "cnt0_cleared");
`endif

        // Reset mid-packet discards buffered data
        out_tready = 1'b0;
        push(1, 32'h70, 1'b0, 1'b0, 1'b0, tdummy);
        push(1, 32'h71, 1'b0, 1'b0, 1'b0, tdummy);
        tick(2);
        rst = 1'b1;
        #1;
        check("rst2_tvalid", 64'(out_tvalid), 64'd0);
        check("rst2_tready", 64'(in_tready), 64'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        reg_op(1'b0, 16'h0008, 32'h0, 32'h0, 1'b0, "rst2_status");
        reg_op(1'b1, 16'h0000, 32'h3, 32'h0, 1'b0, "rst2_enable");
        out_tready = 1'b1;
        tick(6);
        check("rst2_no_output", 64'(out_tvalid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
